// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the four requesters, the downstream sink and the
// round-robin arbiter that steers the 4:1 mux.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] ready;
  logic       out_valid;
  logic       busy;
  logic       drop;

  modport master (
    output req, last, out_ready,
    input  sel, gnt, ready, out_valid, busy, drop
  );

  modport slave (
    input  req, last, out_ready,
    output sel, gnt, ready, out_valid, busy, drop
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter for a 4:1 mux: grants one requester per packet,
// drives the mux select and revokes an owner that stays silent for TMO cycles.
module mux4_rr_arbiter #(
  parameter int TMO = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);
  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_reg;
  logic [1:0]     ptr_reg;
  logic [1:0]     sel_reg;
  logic [3:0]     gnt_reg;
  logic           drop_reg;
  logic [TW-1:0]  tcnt_reg;

  logic [3:0]     rot_req;
  logic [1:0]     pick_next;
  logic [3:0]     pick_onehot;
  logic           owner_req;
  logic           owner_last;

  // rot_req[k] is the request of the requester k places after the pointer
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = bus.req[2'(ptr_reg + 2'(gi))];
    end
  endgenerate

  always_comb begin
    pick_next = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) pick_next = 2'(ptr_reg + 2'(k));
    end
    pick_onehot = 4'b0001 << pick_next;
  end

  assign owner_req  = bus.req[sel_reg];
  assign owner_last = bus.last[sel_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      gnt_reg   <= 4'd0;
      drop_reg  <= 1'b0;
      tcnt_reg  <= '0;
    end else begin
      drop_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_reg <= OWN;
            gnt_reg   <= pick_onehot;
            sel_reg   <= pick_next;
            tcnt_reg  <= '0;
          end
        end
        OWN: begin
          if (owner_req) begin
            tcnt_reg <= '0;
            if (bus.out_ready && owner_last) begin
              state_reg <= IDLE;
              gnt_reg   <= 4'd0;
              ptr_reg   <= 2'(sel_reg + 2'd1);
            end
          end else if (tcnt_reg == TW'(TMO - 1)) begin
            // owner went quiet for TMO cycles: revoke and flag it
            state_reg <= IDLE;
            gnt_reg   <= 4'd0;
            ptr_reg   <= 2'(sel_reg + 2'd1);
            drop_reg  <= 1'b1;
            tcnt_reg  <= '0;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_reg;
  assign bus.gnt       = gnt_reg;
  assign bus.busy      = (state_reg == OWN);
  assign bus.drop      = drop_reg;
  assign bus.ready     = gnt_reg & {4{bus.out_ready}};
  assign bus.out_valid = (state_reg == OWN) & owner_req;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus a randomized run, all
// checked against a packet-level reference model.
module tb_mux4_rr_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  // packet-level reference model
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_quiet = 0;
  logic [1:0] m_sel   = 2'd0;
  logic       m_drop  = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic model_tick();
    m_drop = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_quiet = 0; m_sel = 2'd0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && bus.req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = 2'(m_owner);
          m_quiet = 0;
          $display("grant requester %0d", m_owner);
        end
      end
    end else if (bus.req[m_owner]) begin
      m_quiet = 0;
      if (bus.out_ready && bus.last[m_owner]) begin
        $display("packet end requester %0d", m_owner);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end else if (m_quiet == TMO - 1) begin
      $display("timeout drop requester %0d", m_owner);
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_drop  = 1'b1;
      m_quiet = 0;
    end else begin
      m_quiet++;
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [3:0] eg;
    logic       ov;
    eg = (m_owner < 0) ? 4'd0 : (4'b0001 << m_owner);
    ov = (m_owner < 0) ? 1'b0 : bus.req[m_owner];
    return {eg, m_sel, (m_owner >= 0), m_drop, eg & {4{bus.out_ready}}, ov};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.gnt, bus.sel, bus.busy, bus.drop, bus.ready, bus.out_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 4'hF; bus.last = 4'h0; bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.out_valid} !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold: gnt=%b sel=%0d busy=%b out_valid=%b, required all 0",
                 bus.gnt, bus.sel, bus.busy, bus.out_valid);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_release: gnt=%b sel=%0d, required 0001 sel 0", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [8] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100,
                           4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [1:0] sel_seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    bus.req = 4'hF; bus.last = 4'hF; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.gnt !== seq[i] || bus.sel !== sel_seq[i]) begin
        fails++;
        $display("FAIL rotation[%0d]: gnt=%b sel=%0d, required gnt=%b sel=%0d",
                 i, bus.gnt, bus.sel, seq[i], sel_seq[i]);
      end
    end
  endtask

  task automatic test_pointer_skip();
    bus.req = 4'b1001; bus.last = 4'hF; bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
      fails++;
      $display("FAIL ptr_skip: gnt=%b sel=%0d, required 1000 sel 3", bus.gnt, bus.sel);
    end
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || exp_vec() !== dut_vec()) begin
      fails++;
      $display("FAIL ptr_skip_wrap: gnt=%b vec=%h, required 0001 vec=%h",
               bus.gnt, dut_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.req = 4'b0100; bus.last = 4'b0000; bus.out_ready = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      fails++;
      $display("FAIL bp_grant: gnt=%b, required 0100", bus.gnt);
    end
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = pat[i];
      bus.last      = (i == 4) ? 4'b0100 : 4'b0000;
      #1;
      checks++;
      if (bus.ready !== (pat[i] ? 4'b0100 : 4'b0000) || bus.gnt !== 4'b0100) begin
        fails++;
        $display("FAIL bp_ready[%0d]: ready=%b gnt=%b, required ready=%b gnt=0100",
                 i, bus.ready, bus.gnt, pat[i] ? 4'b0100 : 4'b0000);
      end
      tick();
      checks++;
      if (bus.drop !== 1'b0 || dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL bp_cycle[%0d]: drop=%b vec=%h, required drop 0 vec=%h",
                 i, bus.drop, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.gnt !== 4'b0000) begin
      fails++;
      $display("FAIL bp_clear: gnt=%b, required 0000", bus.gnt);
    end
  endtask

  task automatic test_timeout();
    bus.req = 4'b0010; bus.last = 4'b0000; bus.out_ready = 1'b1;
    tick();
    tick();
    bus.req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.drop !== 1'b0) begin
        fails++;
        $display("FAIL tmo_hold[%0d]: busy=%b drop=%b, required busy 1 drop 0",
                 i, bus.busy, bus.drop);
      end
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.drop !== 1'b1) begin
      fails++;
      $display("FAIL tmo_revoke: busy=%b gnt=%b drop=%b, required 0 0000 1",
               bus.busy, bus.gnt, bus.drop);
    end
    bus.req = 4'b0011;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.drop !== 1'b0) begin
      fails++;
      $display("FAIL tmo_regrant: gnt=%b drop=%b, required 0001 drop 0", bus.gnt, bus.drop);
    end
    bus.last = 4'b0001;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.req = 4'b1000; bus.last = 4'b0000; bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== 13'd0) begin
      fails++;
      $display("FAIL mid_reset: vec=%h, required 0000", dut_vec());
    end
    rst_n = 1'b1; bus.req = 4'hF;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL mid_reset_release: gnt=%b, required 0001", bus.gnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      bus.req       = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.last      = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random_comb[%0d]: vec=%h, required %h", i, dut_vec(), exp_vec());
      end
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random_reg[%0d]: vec=%h, required %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.req = 4'h0; bus.last = 4'h0; bus.out_ready = 1'b0;
    test_reset();
    test_rotation();
    test_pointer_skip();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
